// File: rtl/alu_share_arbiter.sv
// One ALU shared by two requesters with a single registered result slot.
// Contention policy: fixed priority to port 0 by default; define ALU_ARB_ROUND_ROBIN_EN for alternation.
module alu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            i_aluop,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_out,
  output logic                  o_is_zero
);
  localparam int unsigned SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } aluop_e;

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_out = '0;
    case (i_aluop)
      OP_ADD:  o_out = i_a + i_b;
      OP_SUB:  o_out = i_a - i_b;
      OP_SLL:  o_out = i_a << w_shamt;
      OP_SRL:  o_out = i_a >> w_shamt;
      OP_SRA:  o_out = DATA_WIDTH'($signed(i_a) >>> w_shamt);
      OP_AND:  o_out = i_a & i_b;
      OP_OR:   o_out = i_a | i_b;
      OP_XOR:  o_out = i_a ^ i_b;
      OP_SLT:  o_out = DATA_WIDTH'($signed(i_a) < $signed(i_b));
      OP_SLTU: o_out = DATA_WIDTH'(i_a < i_b);
      default: o_out = '0;
    endcase
  end

  assign o_is_zero = (o_out == '0);
endmodule

module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_aluop,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_aluop,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_port,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_is_zero
);
  logic                  r_rsp_valid;
  logic                  r_rsp_port;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_is_zero;
  logic                  r_last_grant;

  logic                  w_slot_free;
  logic                  w_contend_pick;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_gnt;
  logic                  w_sel;
  logic [3:0]            w_aluop;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_alu_out;
  logic                  w_alu_zero;

  assign w_slot_free = !r_rsp_valid || rsp_ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  assign w_contend_pick = ~r_last_grant;
`else
  // last_grant is still tracked so both builds share the same state; it never steers here
  assign w_contend_pick = r_last_grant & 1'b0;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n && w_slot_free) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = !w_contend_pick;
        w_gnt1 = w_contend_pick;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_gnt      = w_gnt0 | w_gnt1;
  assign w_sel      = w_gnt1;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign w_aluop = w_sel ? req1_aluop : req0_aluop;
  assign w_a     = w_sel ? req1_a     : req0_a;
  assign w_b     = w_sel ? req1_b     : req0_b;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_aluop   (w_aluop),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_out     (w_alu_out),
    .o_is_zero (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_port    <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_is_zero <= 1'b0;
      r_last_grant  <= 1'b1;
    end else if (w_gnt) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_port    <= w_sel;
      r_rsp_result  <= w_alu_out;
      r_rsp_is_zero <= w_alu_zero;
      r_last_grant  <= w_sel;
    end else if (rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_port    = r_rsp_port;
  assign rsp_result  = r_rsp_result;
  assign rsp_is_zero = r_rsp_is_zero;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table plus corner-case sequences and a scoreboarded random run for alu_share_arbiter.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_aluop, req1_aluop;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_port, rsp_is_zero;
  logic [31:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
    logic        z;
  } exp_t;

  vec_t vt[13];
  exp_t sb[$];

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_aluop (req0_aluop),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_aluop (req1_aluop),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_port   (rsp_port),
    .rsp_result (rsp_result),
    .rsp_is_zero(rsp_is_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_alu(input logic port, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << b[4:0];
      4'd3: r = a >> b[4:0];
      4'd4: r = $unsigned($signed(a) >>> b[4:0]);
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    e.port = port;
    e.res  = r;
    e.z    = (r == 32'd0);
    return e;
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_aluop = 4'd0; req1_aluop = 4'd0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  initial begin
    exp_t e;
    int   n_acc;
    logic exp_p;

    vt[0]  = '{1'b0, 4'd0,  32'd5,        32'd7,        32'd12,        1'b0};
    vt[1]  = '{1'b1, 4'd1,  32'd9,        32'd9,        32'd0,         1'b1};
    vt[2]  = '{1'b0, 4'd2,  32'd1,        32'd4,        32'd16,        1'b0};
    vt[3]  = '{1'b1, 4'd3,  32'h80000000, 32'd31,       32'd1,         1'b0};
    vt[4]  = '{1'b0, 4'd4,  32'h80000000, 32'd4,        32'hF8000000,  1'b0};
    vt[5]  = '{1'b1, 4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,  1'b0};
    vt[6]  = '{1'b0, 4'd6,  32'h00000F00, 32'h000000F0, 32'h00000FF0,  1'b0};
    vt[7]  = '{1'b1, 4'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,         1'b1};
    vt[8]  = '{1'b0, 4'd8,  32'hFFFFFFFF, 32'd1,        32'd1,         1'b0};
    vt[9]  = '{1'b1, 4'd9,  32'hFFFFFFFF, 32'd1,        32'd0,         1'b1};
    vt[10] = '{1'b1, 4'd12, 32'd123,      32'd456,      32'd0,         1'b1};
    vt[11] = '{1'b0, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,         1'b1};
    vt[12] = '{1'b1, 4'd1,  32'd3,        32'd5,        32'hFFFFFFFE,  1'b0};

    // Reset state, with a requester already asking
    rst_n = 1'b0; rsp_ready = 1'b0;
    idle_inputs();
    req0_valid = 1'b1;
    #2;
    chk("rst_rsp_valid",   rsp_valid,   0);
    chk("rst_rsp_port",    rsp_port,    0);
    chk("rst_rsp_result",  rsp_result,  0);
    chk("rst_rsp_is_zero", rsp_is_zero, 0);
    chk("rst_req0_ready",  req0_ready,  0);
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Directed table, one op per cycle at full throughput
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      idle_inputs();
      rsp_ready = 1'b1;
      if (vt[i].port) begin
        req1_valid = 1'b1; req1_aluop = vt[i].op; req1_a = vt[i].a; req1_b = vt[i].b;
      end else begin
        req0_valid = 1'b1; req0_aluop = vt[i].op; req0_a = vt[i].a; req0_b = vt[i].b;
      end
      #1;
      chk($sformatf("vec%0d_ready", i), {req1_ready, req0_ready}, vt[i].port ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("vec%0d_rsp", i), {rsp_valid, rsp_port, rsp_result, rsp_is_zero},
          {1'b1, vt[i].port, vt[i].res, vt[i].z});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_clears_valid", rsp_valid, 0);

    // Contention right after reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_aluop = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_aluop = 4'd0; req1_a = 32'd2; req1_b = 32'd2;
      rsp_ready = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_p = k[0];
`else
      exp_p = 1'b0;
`endif
      #1;
      chk($sformatf("cont%0d_ready", k), {req1_ready, req0_ready}, exp_p ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      chk($sformatf("cont%0d_rsp", k), {rsp_port, rsp_result},
          {exp_p, exp_p ? 32'd4 : 32'd2});
    end

    // Backpressure: result held, requester blocked; req1 withdraws before any grant
    @(negedge clk);
    idle_inputs();
    req0_valid = 1'b1; req0_aluop = 4'd7; req0_a = 32'hA5; req0_b = 32'h0F;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_aluop = 4'd0; req0_a = 32'd3; req0_b = 32'd4;
      req1_valid = (k < 2); req1_aluop = 4'd0; req1_a = 32'd100; req1_b = 32'd1;
      rsp_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d_ready", k), {req1_ready, req0_ready}, 2'b00);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_hold", k), {rsp_valid, rsp_port, rsp_result, rsp_is_zero},
          {1'b1, 1'b0, 32'hAA, 1'b0});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    chk("bp_release_rsp", {rsp_valid, rsp_port, rsp_result}, {1'b1, 1'b0, 32'd7});

    // Asynchronous reset while a result is pending
    @(negedge clk);
    rsp_ready = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  rsp_valid,  0);
    chk("async_rst_result", rsp_result, 0);
    chk("async_rst_ready",  req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_aluop = 4'd0; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_aluop = 4'd0; req1_a = 32'd30; req1_b = 32'd40;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    chk("post_rst_rsp", {rsp_valid, rsp_port, rsp_result}, {1'b1, 1'b0, 32'd30});

    // Random traffic against the reference model, in acceptance order
    @(negedge clk);
    idle_inputs();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_acc = 0;
    for (int cyc = 0; cyc < 40000 && n_acc < 10000; cyc++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_aluop = 4'($urandom_range(0, 15));
      req1_aluop = 4'($urandom_range(0, 15));
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("rand_sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rand_rsp", {rsp_port, rsp_result, rsp_is_zero}, {e.port, e.res, e.z});
        end
      end
      chk("rand_onehot", req0_ready & req1_ready, 0);
      chk("rand_ready_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);
      if (req0_ready) sb.push_back(ref_alu(1'b0, req0_aluop, req0_a, req0_b));
      if (req1_ready) sb.push_back(ref_alu(1'b1, req1_aluop, req1_a, req1_b));
      if (req0_ready || req1_ready) n_acc++;
    end
    chk("rand_accept_count", (n_acc >= 10000), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      rsp_ready = 1'b1;
      #1;
      if (rsp_valid) begin
        chk("drain_sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("drain_rsp", {rsp_port, rsp_result, rsp_is_zero}, {e.port, e.res, e.z});
        end
      end
    end
    chk("final_sb_empty", sb.size(), 0);
    chk("final_rsp_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  out  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports reqN_aluop  in  4  ALU opcode 0..9 (add,sub,sll,srl,sra,and,or,xor,slt,sltu).
REQ-007 SHALL have ports reqN_a, reqN_b  in  DATA_WIDTH  operands (input0, input1).
REQ-008 SHALL have port rsp_valid  out  1  result register holds a valid result.
REQ-009 SHALL have port rsp_ready  in  1  consumer takes result this cycle.
REQ-010 SHALL have port rsp_port  out  1  index of requester that owns the result.
REQ-011 SHALL have port rsp_result  out  DATA_WIDTH  registered ALU output.
REQ-012 SHALL have port rsp_is_zero  out  1  registered ALU zero flag.

Function
REQ-013 SHALL instantiate one alu (DATA_WIDTH passed through) shared by both requesters; mux selects granted requester's aluop/a/b.
REQ-014 SHALL define slot_free = !rsp_valid || rsp_ready; no grant when slot_free=0, both reqN_ready=0.
REQ-015 SHALL grant at most one requester per cycle; reqN_ready=1 only for granted N, only when reqN_valid=1 and slot_free=1.
REQ-016 SHALL capture ALU out/is_zero and granted index into rsp_result/rsp_is_zero/rsp_port on the grant edge; rsp_valid=1 next cycle (latency 1).
REQ-017 SHALL clear rsp_valid when rsp_ready=1 and no new grant in same cycle; grant plus drain in same cycle keeps rsp_valid=1 with new data (full throughput).
REQ-018 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-019 SHALL keep reqN_ready purely combinational from reqN_valid, rsp_valid, rsp_ready and arbiter state; ready SHALL NOT depend on operand values.
REQ-020 SHALL pass aluop >9 to the ALU unchanged; result 0, is_zero=1.
REQ-021 SHALL track last_grant (1 bit), updated to granted index on every grant, unchanged otherwise.
REQ-022 SHALL, single requester valid: grant it regardless of last_grant.
REQ-023 SHALL, both valid: arbitrate per Configuration section.
REQ-024 SHALL tolerate requester deasserting reqN_valid before grant (no grant, no state change).

Reset
REQ-025 SHALL on rst_n=0 asynchronously force rsp_valid=0, rsp_port=0, rsp_result=0, rsp_is_zero=0, last_grant=1.
REQ-026 SHALL drive reqN_ready=0 while rst_n=0; a pending result is discarded on reset mid-operation.
REQ-027 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL use macro ALU_ARB_ROUND_ROBIN_EN.
REQ-029 SHALL, with ALU_ARB_ROUND_ROBIN_EN defined, on contention grant the port != last_grant (alternation; port 0 first after reset).
REQ-030 SHALL, without ALU_ARB_ROUND_ROBIN_EN, on contention always grant port 0 (fixed priority); last_grant still maintained but unused.

Verification
REQ-031 SHALL cover: reset, req0 add a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_port=0, rsp_result=12, rsp_is_zero=0.
REQ-032 SHALL cover: both valid 4 cycles, rsp_ready=1, RR build -> rsp_port 0,1,0,1; fixed build -> 0,0,0,0, req1_ready never 1.
REQ-033 SHALL cover: rsp_ready=0 with result pending, req0 valid -> req0_ready=0, rsp_* unchanged 3 cycles; rsp_ready=1 -> grant same cycle.
REQ-034 SHALL cover: req1 sub a=9 b=9 -> rsp_result=0, rsp_is_zero=1; req1 aluop=12 -> rsp_result=0, rsp_is_zero=1.
REQ-035 SHALL cover: rst_n low mid-stream with rsp_valid=1 -> rsp_valid=0 immediately (no clk edge), first contention after release granted to port 0.
REQ-036 SHALL cover: 10000 random ops both ports, random valid/ready -> every accepted op yields exactly one result, in acceptance order, matching reference ALU model.
